mmio_interconnect: RTL and testbench

- Parametrised memory-mapped interconnect between the single CORE data port and NSLV slave devices (RAM, switches/buttons, 7-seg, VGA, etc.).
- Decodes the address to one slave and runs a ready-handshake transaction to it.
- Adds per-access wait states, timeout and decode-error reporting, and error statistics, none of which exist in the fixed single-memory hookup.

---
 rtl/mmio_interconnect_if.sv | 52 +++++
 rtl/mmio_interconnect.sv | 137 +++++++++++++
 tb/tb_mmio_interconnect.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_interconnect_if.sv
// ---------------------------------------------------------------------------
// mmio_interconnect_if
// Bundles the core-side request/response signals, the shared slave bus and
// the error-statistics outputs of mmio_interconnect.
//   slave  modport : the interconnect's view (answers core requests, drives
//                    the slave bus, reports error statistics).
//   master modport : the environment's view (core plus slave devices).
// Signals:
//   memread_i/memwrite_i/memaddr_i/memwdata_i : core request
//   memrdata_o/memready_o/memerr_o            : core response
//   slv_sel_o/slv_read_o/slv_write_o          : slave select and strobes
//   slv_addr_o/slv_wdata_o                    : latched address / write data
//   slv_rdata_i/slv_ready_i                   : per-slave read data / ready
//   err_count_o/err_addr_o                    : error statistics
// ---------------------------------------------------------------------------
interface mmio_interconnect_if #(
    parameter int WIDTH = 32,
    parameter int NSLV  = 4
);
    logic                  memread_i;
    logic                  memwrite_i;
    logic [WIDTH-1:0]      memaddr_i;
    logic [WIDTH-1:0]      memwdata_i;
    logic [WIDTH-1:0]      memrdata_o;
    logic                  memready_o;
    logic                  memerr_o;
    logic [NSLV-1:0]       slv_sel_o;
    logic                  slv_read_o;
    logic                  slv_write_o;
    logic [WIDTH-1:0]      slv_addr_o;
    logic [WIDTH-1:0]      slv_wdata_o;
    logic [NSLV*WIDTH-1:0] slv_rdata_i;
    logic [NSLV-1:0]       slv_ready_i;
    logic [7:0]            err_count_o;
    logic [WIDTH-1:0]      err_addr_o;

    modport slave (
        input  memread_i, memwrite_i, memaddr_i, memwdata_i,
        input  slv_rdata_i, slv_ready_i,
        output memrdata_o, memready_o, memerr_o,
        output slv_sel_o, slv_read_o, slv_write_o, slv_addr_o, slv_wdata_o,
        output err_count_o, err_addr_o
    );

    modport master (
        output memread_i, memwrite_i, memaddr_i, memwdata_i,
        output slv_rdata_i, slv_ready_i,
        input  memrdata_o, memready_o, memerr_o,
        input  slv_sel_o, slv_read_o, slv_write_o, slv_addr_o, slv_wdata_o,
        input  err_count_o, err_addr_o
    );
endinterface

// File: rtl/mmio_interconnect.sv
// ---------------------------------------------------------------------------
// mmio_interconnect
// Memory-mapped interconnect between the core data port and NSLV slaves.
// The slave index is taken from addr[SEL_LSB +: SEL_BITS]; any address bit
// above that field being set, or an index >= NSLV, is a decode error.
// Each access runs IDLE -> ACCESS -> RESP (or IDLE -> RESP on decode error),
// with a TIMEOUT-bounded wait for the selected slave's ready. Errors return
// ERR_DATA on reads and update a saturating counter and last-error address.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : mmio_interconnect_if.slave (core request/response, slave bus,
//         error statistics)
// ---------------------------------------------------------------------------
module mmio_interconnect #(
    parameter int               WIDTH    = 32,
    parameter int               NSLV     = 4,
    parameter int               SEL_LSB  = 12,
    parameter int               SEL_BITS = 2,
    parameter int               TIMEOUT  = 255,
    parameter logic [WIDTH-1:0] ERR_DATA = WIDTH'(32'hDEAD_BEEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_interconnect_if.slave   bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                wr_q;
    logic [SEL_BITS-1:0] idx_q;

    logic [SEL_BITS-1:0] idx;
    logic [WIDTH-1:0]    upper;
    logic                dec_err;
    logic [NSLV-1:0]     onehot;
    logic                ready_sel;
    logic [WIDTH-1:0]    rdata_sel;
    logic [7:0]          err_inc;

    always_comb begin
        idx       = bus.memaddr_i[SEL_LSB +: SEL_BITS];
        upper     = bus.memaddr_i >> (SEL_LSB + SEL_BITS);
        dec_err   = (int'(idx) >= NSLV) || (upper != '0);
        onehot    = '0;
        ready_sel = 1'b0;
        rdata_sel = '0;
        // Select from the live request index; ready/rdata from the latched one.
        for (int unsigned k = 0; k < NSLV; k++) begin
            if (idx == SEL_BITS'(k)) onehot[k] = 1'b1;
            if (idx_q == SEL_BITS'(k)) begin
                ready_sel = bus.slv_ready_i[k];
                rdata_sel = bus.slv_rdata_i[k*WIDTH +: WIDTH];
            end
        end
        err_inc = (bus.err_count_o == 8'hFF) ? 8'hFF : bus.err_count_o + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            wr_q            <= 1'b0;
            idx_q           <= '0;
            bus.memrdata_o  <= '0;
            bus.memready_o  <= 1'b0;
            bus.memerr_o    <= 1'b0;
            bus.slv_sel_o   <= '0;
            bus.slv_read_o  <= 1'b0;
            bus.slv_write_o <= 1'b0;
            bus.slv_addr_o  <= '0;
            bus.slv_wdata_o <= '0;
            bus.err_count_o <= '0;
            bus.err_addr_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.memread_i || bus.memwrite_i) begin
                        bus.slv_addr_o  <= bus.memaddr_i;
                        bus.slv_wdata_o <= bus.memwdata_i;
                        wr_q            <= bus.memwrite_i;
                        idx_q           <= idx;
                        if (dec_err) begin
                            state           <= RESP;
                            bus.memready_o  <= 1'b1;
                            bus.memerr_o    <= 1'b1;
                            bus.memrdata_o  <= bus.memwrite_i ? '0 : ERR_DATA;
                            bus.err_count_o <= err_inc;
                            bus.err_addr_o  <= bus.memaddr_i;
                        end else begin
                            state           <= ACCESS;
                            cnt             <= '0;
                            bus.slv_sel_o   <= onehot;
                            bus.slv_read_o  <= ~bus.memwrite_i;
                            bus.slv_write_o <= bus.memwrite_i;
                        end
                    end
                end
                ACCESS: begin
                    // Ready wins over timeout in the final wait cycle.
                    if (ready_sel) begin
                        state           <= RESP;
                        bus.slv_sel_o   <= '0;
                        bus.slv_read_o  <= 1'b0;
                        bus.slv_write_o <= 1'b0;
                        bus.memready_o  <= 1'b1;
                        bus.memerr_o    <= 1'b0;
                        bus.memrdata_o  <= wr_q ? '0 : rdata_sel;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        state           <= RESP;
                        bus.slv_sel_o   <= '0;
                        bus.slv_read_o  <= 1'b0;
                        bus.slv_write_o <= 1'b0;
                        bus.memready_o  <= 1'b1;
                        bus.memerr_o    <= 1'b1;
                        bus.memrdata_o  <= wr_q ? '0 : ERR_DATA;
                        bus.err_count_o <= err_inc;
                        bus.err_addr_o  <= bus.slv_addr_o;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    bus.memready_o <= 1'b0;
                    bus.memerr_o   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_interconnect.sv
// ---------------------------------------------------------------------------
// tb_mmio_interconnect
// Self-checking bench for mmio_interconnect (TIMEOUT=4). Directed scenarios
// plus randomized back-to-back traffic compared against a transaction-level
// reference model of latency, error, read data and error statistics.
// ---------------------------------------------------------------------------
module tb_mmio_interconnect;

    localparam int          WIDTH    = 32;
    localparam int          NSLV     = 4;
    localparam int          SEL_LSB  = 12;
    localparam int          SEL_BITS = 2;
    localparam int          TIMEOUT  = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    int          m_err_count = 0;
    logic [31:0] m_err_addr  = '0;
    logic [31:0] sd [4];

    mmio_interconnect_if #(.WIDTH(WIDTH), .NSLV(NSLV)) bus ();

    mmio_interconnect #(
        .WIDTH(WIDTH), .NSLV(NSLV), .SEL_LSB(SEL_LSB), .SEL_BITS(SEL_BITS),
        .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: expected outcome of one transaction.
    function automatic void model(input logic wr, input logic [31:0] addr,
                                  input int wait_n, output int e_lat,
                                  output logic e_err, output logic [31:0] e_rd,
                                  output int e_sc);
        logic [31:0] a;
        logic [1:0]  idx;
        a   = addr;
        idx = a[13:12];
        if ((addr >> 14) != 0) begin
            e_lat = 1; e_err = 1'b1; e_sc = 0;
        end else if (wait_n <= TIMEOUT) begin
            e_lat = wait_n + 2; e_err = 1'b0; e_sc = wait_n + 1;
        end else begin
            e_lat = TIMEOUT + 2; e_err = 1'b1; e_sc = TIMEOUT + 1;
        end
        e_rd = wr ? 32'h0 : (e_err ? ERR_DATA : sd[idx]);
        if (e_err) begin
            if (m_err_count < 255) m_err_count++;
            m_err_addr = addr;
        end
    endfunction

    task automatic load_slaves();
        for (int k = 0; k < 4; k++) sd[k] = $urandom;
        bus.slv_rdata_i = {sd[3], sd[2], sd[1], sd[0]};
    endtask

    // Core + slave driver. Starts a request in the next cycle (cycle 0),
    // acts as the addressed slave with wait_n wait cycles, toggles other
    // slaves' ready randomly, and returns what the core observed.
    task automatic run_txn(input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int wait_n, output int lat, output logic err,
                           output logic [31:0] rdata, output int bad,
                           output int sc);
        logic [31:0] a;
        logic [1:0]  idx;
        logic [3:0]  me;
        logic        done;
        a    = addr;
        idx  = a[13:12];
        me   = 4'b0001 << idx;
        lat  = -1; err = 1'b0; rdata = '0; bad = 0; sc = 0; done = 1'b0;
        @(posedge clk); #1;
        bus.memread_i   = rd;
        bus.memwrite_i  = wr;
        bus.memaddr_i   = addr;
        bus.memwdata_i  = wdata;
        bus.slv_ready_i = 4'($urandom) & ~me;
        for (int c = 1; c <= 64 && !done; c++) begin
            @(posedge clk); #1;
            if (bus.memready_o === 1'b1) begin
                lat   = c;
                err   = bus.memerr_o;
                rdata = bus.memrdata_o;
                if (bus.slv_sel_o !== 4'b0 || bus.slv_read_o !== 1'b0 ||
                    bus.slv_write_o !== 1'b0) bad++;
                done = 1'b1;
            end else begin
                if (bus.slv_sel_o !== 4'b0) begin
                    sc++;
                    if (bus.slv_sel_o !== me || bus.slv_read_o !== ~wr ||
                        bus.slv_write_o !== wr || bus.slv_addr_o !== addr ||
                        bus.slv_wdata_o !== wdata) bad++;
                end else if (bus.slv_read_o !== 1'b0 || bus.slv_write_o !== 1'b0) begin
                    bad++;
                end
                bus.slv_ready_i = (4'($urandom) & ~me) |
                    ((((bus.slv_sel_o & me) != 4'b0) && (sc - 1 >= wait_n)) ? me : 4'b0);
            end
        end
        bus.memread_i   = 1'b0;
        bus.memwrite_i  = 1'b0;
        bus.slv_ready_i = 4'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.memread_i = 1'b0; bus.memwrite_i = 1'b0;
        bus.memaddr_i = '0; bus.memwdata_i = '0;
        bus.slv_ready_i = '0; bus.slv_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.memrdata_o, bus.memready_o, bus.memerr_o, bus.slv_sel_o,
             bus.slv_read_o, bus.slv_write_o, bus.slv_addr_o, bus.slv_wdata_o,
             bus.err_count_o, bus.err_addr_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: memready=%b sel=%b err_count=%0d addr=%h, all required 0",
                     bus.memready_o, bus.slv_sel_o, bus.err_count_o, bus.slv_addr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        m_err_count = 0; m_err_addr = '0;
    endtask

    task automatic test_read_basic();
        int lat, bad, sc, e_lat, e_sc; logic err, e_err; logic [31:0] rd, e_rd;
        load_slaves();
        sd[1] = 32'h1234_5678;
        bus.slv_rdata_i = {sd[3], sd[2], sd[1], sd[0]};
        model(1'b0, 32'h0000_1004, 0, e_lat, e_err, e_rd, e_sc);
        run_txn(1'b1, 1'b0, 32'h0000_1004, 32'h0, 0, lat, err, rd, bad, sc);
        checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL read_basic: lat=%0d err=%b rdata=%h, required 2 0 12345678", lat, err, rd);
        end
        checks++;
        if (bad !== 0 || sc !== 1) begin
            errors++;
            $display("FAIL read_basic_sel: bad=%0d sel_cycles=%0d, required 0 1", bad, sc);
        end
    endtask

    task automatic test_write_wait();
        int lat, bad, sc, e_lat, e_sc; logic err, e_err; logic [31:0] rd, e_rd;
        load_slaves();
        model(1'b1, 32'h0000_2000, 3, e_lat, e_err, e_rd, e_sc);
        run_txn(1'b0, 1'b1, 32'h0000_2000, 32'hA5A5_A5A5, 3, lat, err, rd, bad, sc);
        checks++;
        if (lat !== 5 || err !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL write_wait: lat=%0d err=%b rdata=%h, required 5 0 0", lat, err, rd);
        end
        checks++;
        if (bad !== 0 || sc !== 4) begin
            errors++;
            $display("FAIL write_wait_strobe: bad=%0d write_cycles=%0d, required 0 4", bad, sc);
        end
    endtask

    task automatic test_decode_err();
        int lat, bad, sc, e_lat, e_sc; logic err, e_err; logic [31:0] rd, e_rd;
        load_slaves();
        model(1'b0, 32'h0001_0000, 0, e_lat, e_err, e_rd, e_sc);
        run_txn(1'b1, 1'b0, 32'h0001_0000, 32'h0, 0, lat, err, rd, bad, sc);
        checks++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'hDEAD_BEEF || sc !== 0 || bad !== 0) begin
            errors++;
            $display("FAIL decode_err: lat=%0d err=%b rdata=%h sel_cycles=%0d, required 1 1 deadbeef 0",
                     lat, err, rd, sc);
        end
        checks++;
        if (bus.err_count_o !== 8'd1 || bus.err_addr_o !== 32'h0001_0000) begin
            errors++;
            $display("FAIL decode_err_stats: count=%0d addr=%h, required 1 00010000",
                     bus.err_count_o, bus.err_addr_o);
        end
    endtask

    task automatic test_timeout();
        int lat, bad, sc, e_lat, e_sc; logic err, e_err; logic [31:0] rd, e_rd;
        load_slaves();
        model(1'b0, 32'h0000_3010, 1000, e_lat, e_err, e_rd, e_sc);
        run_txn(1'b1, 1'b0, 32'h0000_3010, 32'h0, 1000, lat, err, rd, bad, sc);
        checks++;
        if (lat !== 6 || err !== 1'b1 || rd !== 32'hDEAD_BEEF || sc !== 5) begin
            errors++;
            $display("FAIL timeout: lat=%0d err=%b rdata=%h sel_cycles=%0d, required 6 1 deadbeef 5",
                     lat, err, rd, sc);
        end
        checks++;
        if (bus.err_count_o !== 8'd2 || bus.err_addr_o !== 32'h0000_3010) begin
            errors++;
            $display("FAIL timeout_stats: count=%0d addr=%h, required 2 00003010",
                     bus.err_count_o, bus.err_addr_o);
        end
    endtask

    task automatic test_both();
        int lat, bad, sc, e_lat, e_sc; logic err, e_err; logic [31:0] rd, e_rd;
        load_slaves();
        model(1'b1, 32'h0000_0008, 1, e_lat, e_err, e_rd, e_sc);
        run_txn(1'b1, 1'b1, 32'h0000_0008, 32'h0BAD_F00D, 1, lat, err, rd, bad, sc);
        checks++;
        if (lat !== 3 || err !== 1'b0 || rd !== 32'h0 || bad !== 0 || sc !== 2) begin
            errors++;
            $display("FAIL both_as_write: lat=%0d err=%b rdata=%h bad=%0d, required 3 0 0 0",
                     lat, err, rd, bad);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bad, sc, e_lat, e_sc, w; logic err, e_err, r, wr;
        logic [31:0] rd, e_rd, addr, wd;
        int sel;
        for (int n = 0; n < 300; n++) begin
            load_slaves();
            sel = $urandom_range(0, 2);
            r   = (sel != 1);
            wr  = (sel != 0);
            if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0000_4000;
            else addr = {18'b0, 2'($urandom), 12'($urandom)};
            wd = $urandom;
            w  = $urandom_range(0, 6);
            model(wr, addr, w, e_lat, e_err, e_rd, e_sc);
            run_txn(r, wr, addr, wd, w, lat, err, rd, bad, sc);
            checks++;
            if (lat !== e_lat || err !== e_err || rd !== e_rd || bad !== 0 || sc !== e_sc) begin
                errors++;
                $display("FAIL b2b_txn[%0d] addr=%h wr=%b wait=%0d: lat=%0d err=%b rdata=%h sel=%0d bad=%0d, required lat=%0d err=%b rdata=%h sel=%0d bad=0",
                         n, addr, wr, w, lat, err, rd, sc, bad, e_lat, e_err, e_rd, e_sc);
            end
            checks++;
            if (bus.err_count_o !== 8'(m_err_count) || bus.err_addr_o !== m_err_addr) begin
                errors++;
                $display("FAIL b2b_stats[%0d]: count=%0d addr=%h, required %0d %h",
                         n, bus.err_count_o, bus.err_addr_o, m_err_count, m_err_addr);
            end
        end
    endtask

    task automatic test_saturation();
        int lat, bad, sc, e_lat, e_sc; logic err, e_err; logic [31:0] rd, e_rd, addr;
        for (int n = 0; n < 260; n++) begin
            addr = $urandom | 32'h8000_0000;
            model(1'b0, addr, 0, e_lat, e_err, e_rd, e_sc);
            run_txn(1'b1, 1'b0, addr, 32'h0, 0, lat, err, rd, bad, sc);
        end
        checks++;
        if (bus.err_count_o !== 8'(m_err_count) || m_err_count != 255 ||
            bus.err_addr_o !== m_err_addr || err !== 1'b1) begin
            errors++;
            $display("FAIL saturation: count=%0d addr=%h err=%b, required 255 %h 1",
                     bus.err_count_o, bus.err_addr_o, err, m_err_addr);
        end
    endtask

    task automatic test_rst_during_access();
        int spurious;
        @(posedge clk); #1;
        bus.memread_i   = 1'b1;
        bus.memaddr_i   = 32'h0000_0010;
        bus.slv_ready_i = 4'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.slv_sel_o !== 4'b0001 || bus.slv_read_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_access_sel: sel=%b read=%b, required 0001 1", bus.slv_sel_o, bus.slv_read_o);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.memrdata_o, bus.memready_o, bus.memerr_o, bus.slv_sel_o,
             bus.slv_read_o, bus.slv_write_o, bus.slv_addr_o, bus.slv_wdata_o,
             bus.err_count_o, bus.err_addr_o} !== '0) begin
            errors++;
            $display("FAIL rst_access_outputs: sel=%b read=%b count=%0d addr=%h, all required 0",
                     bus.slv_sel_o, bus.slv_read_o, bus.err_count_o, bus.slv_addr_o);
        end
        bus.memread_i = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        m_err_count = 0; m_err_addr = '0;
        spurious = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.memready_o !== 1'b0 || bus.slv_sel_o !== 4'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL rst_access_quiet: activity_cycles=%0d, required 0", spurious);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_wait();
        test_decode_err();
        test_timeout();
        test_both();
        test_back_to_back();
        test_saturation();
        test_rst_during_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
